// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-ported unified memory between the multicycle
// CPU and the debug/loader port. One transaction at a time; each transaction
// drives the memory for WAIT_CYCLES cycles, then pulses the winner's ack for
// one cycle with read data held in a shared rdata register.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   cpu_req/we/addr/wdata    CPU request (level), held until cpu_ack
//   cpu_rdata, cpu_ack       shared read data register, one-cycle completion pulse
//   dbg_req/we/addr/wdata    debug port request, same contract as the CPU
//   dbg_rdata, dbg_ack       same rdata register, one-cycle completion pulse
//   dbg_halt                 while high, CPU requests are not granted
//   mem_en/we/addr/wdata     memory drive; mem_we only on the final access cycle
//   mem_rdata                memory read data, valid while mem_en is high
//   busy                     high whenever not idle
//   grant_dbg                current or most recent grant went to the debug port
module mem_arbiter #(
  parameter int WIDTH       = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_ack,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [WIDTH-1:0] dbg_addr,
  input  logic [WIDTH-1:0] dbg_wdata,
  output logic [WIDTH-1:0] dbg_rdata,
  output logic             dbg_ack,
  input  logic             dbg_halt,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             grant_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic             last_dbg;   // round-robin memory: winner of the previous grant
  logic             gnt_dbg;    // owner of the current transaction (drives the acks)
  logic             lat_we;
  logic [WIDTH-1:0] lat_addr;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] rdata;

  logic cpu_elig;
  logic dbg_elig;
  logic win_dbg;

  // On a tie the requester that lost the previous grant wins.
  always_comb begin
    cpu_elig = cpu_req && !dbg_halt;
    dbg_elig = dbg_req;
    win_dbg  = (cpu_elig && dbg_elig) ? !last_dbg : dbg_elig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      last_dbg  <= 1'b1;
      gnt_dbg   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_elig || dbg_elig) begin
            state     <= ACCESS;
            cnt       <= CNT_LOAD;
            last_dbg  <= win_dbg;
            gnt_dbg   <= win_dbg;
            lat_we    <= win_dbg ? dbg_we    : cpu_we;
            lat_addr  <= win_dbg ? dbg_addr  : cpu_addr;
            lat_wdata <= win_dbg ? dbg_wdata : cpu_wdata;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we) rdata <= mem_rdata;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; the memory strobes are additionally gated by rst so that a
  // reset landing on the final access cycle never produces a write.
  always_comb begin
    busy      = (state != IDLE);
    mem_en    = (state == ACCESS) && !rst;
    mem_we    = (state == ACCESS) && (cnt == '0) && lat_we && !rst;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    cpu_ack   = (state == DONE) && !gnt_dbg;
    dbg_ack   = (state == DONE) && gnt_dbg;
    cpu_rdata = rdata;
    dbg_rdata = rdata;
    grant_dbg = gnt_dbg;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: three instances (WAIT_CYCLES = 2, 1, 5) share one
// set of inputs. A transaction-level reference model checks every output of
// every instance each cycle; a vector table and directed sequences pin down
// the documented scenarios on the WAIT_CYCLES=2 instance.
module tb_mem_arbiter;

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_halt = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] o_cpu_rdata[3], o_dbg_rdata[3], o_mem_addr[3], o_mem_wdata[3];
  logic        o_cpu_ack[3], o_dbg_ack[3], o_mem_en[3], o_mem_we[3], o_busy[3], o_grant_dbg[3];

  function automatic int wfor(int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 5;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.WIDTH(32), .WAIT_CYCLES((g == 0) ? 2 : (g == 1) ? 1 : 5)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(o_cpu_rdata[g]), .cpu_ack(o_cpu_ack[g]),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_rdata(o_dbg_rdata[g]), .dbg_ack(o_dbg_ack[g]),
      .dbg_halt(dbg_halt),
      .mem_en(o_mem_en[g]), .mem_we(o_mem_we[g]), .mem_addr(o_mem_addr[g]),
      .mem_wdata(o_mem_wdata[g]), .mem_rdata(mem_rdata),
      .busy(o_busy[g]), .grant_dbg(o_grant_dbg[g])
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is "age" cycles old after its grant edge.
  // Ages 1..W are memory-access cycles, age W+1 is the acknowledge cycle.
  typedef struct {
    bit          valid;
    bit          active;
    int          age;
    bit          who_dbg;
    bit          we;
    logic [31:0] addr, wdata, rdata;
    bit          last_dbg;
    bit          gd;
  } model_t;

  model_t mdl[3];

  function automatic logic [159:0] exp_vec(model_t m, int w, logic r);
    logic acc, done;
    acc  = m.active && (m.age <= w);
    done = m.active && (m.age == w + 1);
    return {26'b0, m.active, acc && !r, acc && (m.age == w) && m.we && !r,
            done && !m.who_dbg, done && m.who_dbg, m.gd,
            m.rdata, m.rdata, m.addr, m.wdata};
  endfunction

  function automatic logic [159:0] obs_vec(int g);
    return {26'b0, o_busy[g], o_mem_en[g], o_mem_we[g], o_cpu_ack[g], o_dbg_ack[g],
            o_grant_dbg[g], o_cpu_rdata[g], o_dbg_rdata[g], o_mem_addr[g], o_mem_wdata[g]};
  endfunction

  function automatic model_t advance(model_t m, int w);
    model_t n;
    bit ce, win;
    n = m;
    if (rst) begin
      n.valid = 1; n.active = 0; n.age = 0; n.who_dbg = 0; n.we = 0;
      n.addr = '0; n.wdata = '0; n.rdata = '0; n.last_dbg = 1; n.gd = 0;
    end else if (n.active) begin
      if (n.age == w && !n.we) n.rdata = mem_rdata;
      n.age++;
      if (n.age > w + 1) n.active = 0;
    end else begin
      ce = cpu_req && !dbg_halt;
      if (ce || dbg_req) begin
        win       = (ce && dbg_req) ? !n.last_dbg : dbg_req;
        n.active  = 1; n.age = 1; n.who_dbg = win; n.last_dbg = win; n.gd = win;
        n.we      = win ? dbg_we : cpu_we;
        n.addr    = win ? dbg_addr : cpu_addr;
        n.wdata   = win ? dbg_wdata : cpu_wdata;
      end
    end
    return n;
  endfunction

  // Snapshots of instance outputs taken mid-cycle.
  logic        s_busy[3], s_en[3], s_we[3], s_cack[3], s_dack[3], s_gd[3];
  logic [31:0] s_rdata[3], s_addr[3];

  // One clock cycle: check at the falling edge, advance the model on the
  // rising edge, return 1 time unit later so the caller can drive new inputs.
  task automatic step();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      s_busy[g] = o_busy[g]; s_en[g] = o_mem_en[g]; s_we[g] = o_mem_we[g];
      s_cack[g] = o_cpu_ack[g]; s_dack[g] = o_dbg_ack[g]; s_gd[g] = o_grant_dbg[g];
      s_rdata[g] = o_cpu_rdata[g]; s_addr[g] = o_mem_addr[g];
      if (mdl[g].valid) chk($sformatf("model_w%0d", wfor(g)), obs_vec(g), exp_vec(mdl[g], wfor(g), rst));
    end
    @(posedge clk);
    for (int g = 0; g < 3; g++) mdl[g] = advance(mdl[g], wfor(g));
    #1;
  endtask

  task automatic clear_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_halt = 0;
  endtask

  typedef struct {
    logic        rst, creq, cwe;
    logic [31:0] caddr;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic        halt;
    logic [31:0] mrd;
    logic        busy, en, we, cack, dack;
    logic [31:0] rdata;
    logic        gd;
    logic [31:0] maddr;
  } vec_t;

  vec_t tv[11];

  initial begin
    int          ack_cyc[$];
    bit          ack_who[$];
    int          lat[3];
    logic [31:0] rd[3];
    bit          bad, cpend, dpend;
    int          l;

    for (int g = 0; g < 3; g++) mdl[g].valid = 0;

    // Reset, CPU read of 0x10, then debug write of 0x12345678 to 0x40.
    //           rst creq cwe caddr     dreq dwe daddr     dwdata        halt mrd           busy en we ca da rdata          gd maddr
    tv[0]  = '{1, 0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0};
    tv[1]  = '{1, 0, 0, 32'h0,  0, 0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0};
    tv[2]  = '{0, 1, 0, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h0,        0, 32'h0};
    tv[3]  = '{0, 1, 0, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 1, 1, 0, 0, 0, 32'h0,        0, 32'h10};
    tv[4]  = '{0, 1, 0, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 1, 1, 0, 0, 0, 32'h0,        0, 32'h10};
    tv[5]  = '{0, 1, 0, 32'h10, 0, 0, 32'h0,  32'h0,        0, 32'hDEADBEEF, 1, 0, 0, 1, 0, 32'hDEADBEEF, 0, 32'h10};
    tv[6]  = '{0, 0, 0, 32'h10, 1, 1, 32'h40, 32'h12345678, 0, 32'hBAD0BAD0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 32'h10};
    tv[7]  = '{0, 0, 0, 32'h10, 1, 1, 32'h40, 32'h12345678, 0, 32'hBAD0BAD0, 1, 1, 0, 0, 0, 32'hDEADBEEF, 1, 32'h40};
    tv[8]  = '{0, 0, 0, 32'h10, 1, 1, 32'h40, 32'h12345678, 0, 32'hBAD0BAD0, 1, 1, 1, 0, 0, 32'hDEADBEEF, 1, 32'h40};
    tv[9]  = '{0, 0, 0, 32'h10, 1, 1, 32'h40, 32'h12345678, 0, 32'hBAD0BAD0, 1, 0, 0, 0, 1, 32'hDEADBEEF, 1, 32'h40};
    tv[10] = '{0, 0, 0, 32'h10, 0, 0, 32'h40, 32'h12345678, 0, 32'hBAD0BAD0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 1, 32'h40};

    clear_inputs();
    rst = 1;
    #1;
    step();
    for (int i = 0; i < 11; i++) begin
      rst = tv[i].rst; cpu_req = tv[i].creq; cpu_we = tv[i].cwe; cpu_addr = tv[i].caddr;
      dbg_req = tv[i].dreq; dbg_we = tv[i].dwe; dbg_addr = tv[i].daddr; dbg_wdata = tv[i].dwdata;
      dbg_halt = tv[i].halt; mem_rdata = tv[i].mrd;
      step();
      chk($sformatf("table_row%0d", i),
          {90'b0, s_busy[0], s_en[0], s_we[0], s_cack[0], s_dack[0], s_gd[0], s_rdata[0], s_addr[0]},
          {90'b0, tv[i].busy, tv[i].en, tv[i].we, tv[i].cack, tv[i].dack, tv[i].gd, tv[i].rdata, tv[i].maddr});
    end

    // Round-robin: both requesters held for four transactions.
    clear_inputs(); rst = 1; step(); rst = 0;
    cpu_req = 1; cpu_addr = 32'h100; dbg_req = 1; dbg_addr = 32'h200;
    for (int c = 0; c < 40 && ack_cyc.size() < 4; c++) begin
      mem_rdata = $urandom;
      step();
      if (s_cack[0] || s_dack[0]) begin
        ack_cyc.push_back(c);
        ack_who.push_back(s_dack[0]);
      end
    end
    chk("rr_ack_count", 160'(ack_cyc.size()), 160'(4));
    for (int i = 0; i < ack_cyc.size(); i++) begin
      chk($sformatf("rr_grant%0d", i), 160'(ack_who[i]), 160'(i % 2));
      if (i > 0) chk($sformatf("rr_spacing%0d", i), 160'(ack_cyc[i] - ack_cyc[i-1]), 160'(4));
    end

    // Halt: CPU request blocked for 10 cycles, then served after release.
    clear_inputs(); rst = 1; step(); rst = 0;
    dbg_halt = 1; cpu_req = 1; cpu_addr = 32'h20; mem_rdata = 32'h0F0F0F0F;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      bad |= s_busy[0] | s_cack[0] | s_dack[0];
    end
    chk("halt_quiet", 160'(bad), 160'(0));
    dbg_halt = 0;
    l = -1;
    for (int c = 0; c < 10 && l < 0; c++) begin
      step();
      if (s_cack[0]) l = c;
    end
    chk("halt_release_latency", 160'(l), 160'(3));
    chk("halt_release_rdata", 160'(s_rdata[0]), 160'(32'h0F0F0F0F));

    // Reset landing on the final access cycle of a write.
    clear_inputs(); rst = 1; step(); rst = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h80; dbg_wdata = 32'hA5A5A5A5;
    step();
    step();
    chk("rst_mid_access", 160'(s_en[0]), 160'(1));
    bad = s_we[0] | s_dack[0];
    rst = 1;
    step();
    bad |= s_we[0] | s_dack[0];
    chk("rst_mid_en", 160'(s_en[0]), 160'(0));
    rst = 0; dbg_req = 0;
    step();
    bad |= s_we[0] | s_dack[0];
    chk("rst_mid_no_we_no_ack", 160'(bad), 160'(0));
    chk("rst_mid_idle", 160'(s_busy[0]), 160'(0));
    chk("rst_mid_rdata", 160'(s_rdata[0]), 160'(0));

    // Wait-cycle sweep: same read on all three instances.
    clear_inputs(); rst = 1; step(); rst = 0;
    cpu_req = 1; cpu_addr = 32'h10; mem_rdata = 32'hDEADBEEF;
    for (int g = 0; g < 3; g++) begin lat[g] = -1; rd[g] = '0; end
    for (int c = 0; c < 12; c++) begin
      step();
      for (int g = 0; g < 3; g++)
        if (s_cack[g] && lat[g] < 0) begin lat[g] = c; rd[g] = s_rdata[g]; end
    end
    chk("sweep_latency_w2", 160'(lat[0]), 160'(3));
    chk("sweep_latency_w1", 160'(lat[1]), 160'(2));
    chk("sweep_latency_w5", 160'(lat[2]), 160'(6));
    for (int g = 0; g < 3; g++)
      chk($sformatf("sweep_rdata_w%0d", wfor(g)), 160'(rd[g]), 160'(32'hDEADBEEF));

    // Randomized traffic; requesters follow the hold-until-ack contract of
    // the WAIT_CYCLES=2 instance, the model checks all three every cycle.
    clear_inputs(); rst = 1; step(); rst = 0;
    cpend = 0; dpend = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!cpend && $urandom_range(2) == 0) begin
        cpend = 1; cpu_we = 1'($urandom_range(1)); cpu_addr = $urandom; cpu_wdata = $urandom;
      end
      if (!dpend && $urandom_range(2) == 0) begin
        dpend = 1; dbg_we = 1'($urandom_range(1)); dbg_addr = $urandom; dbg_wdata = $urandom;
      end
      cpu_req = cpend;
      dbg_req = dpend;
      if ($urandom_range(7) == 0) dbg_halt = ~dbg_halt;
      rst = ($urandom_range(99) == 0);
      mem_rdata = $urandom;
      step();
      if (s_cack[0]) cpend = 0;
      if (s_dack[0]) dpend = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
